multicycle_adder: RTL and testbench
===================================

// Module: multicycle_adder
// PURPOSE
//  Parametrised N-bit adder that computes A+B+Cin over WIDTH/CHUNK clock cycles, CHUNK bits per cycle.
//  Successor to the combinational two-bit adder. Adds a start/busy/done handshake, registered results
//  and signed-overflow detection. Used wherever a wide add can trade latency for a narrow carry chain.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits; must be >= 1
//  CHUNK  2  bits added per cycle; WIDTH % CHUNK == 0 (elaboration error otherwise)
//  (local) STEPS = WIDTH/CHUNK  processing cycles per operation
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  start     in   1      request; sampled only when accepting (see BEHAVIOUR)
//  A         in   WIDTH  operand A, sampled on the accepting edge only
//  B         in   WIDTH  operand B, sampled on the accepting edge only
//  Cin       in   1      carry in, sampled on the accepting edge only
//  busy      out  1      operation in progress
//  done      out  1      one-cycle pulse: S/Cout/overflow valid
//  S         out  WIDTH  sum, registered; held until the next accepted start
//  Cout      out  1      carry out of bit WIDTH-1, registered, held
//  overflow  out  1      signed overflow (carry into MSB XOR Cout), registered, held
// BEHAVIOUR
//  - Reset (async assert, sync deassert use): state=IDLE, busy=0, done=0, S=0, Cout=0, overflow=0,
//    counter=0, operand shift registers=0. Reset mid-operation abandons the operation; no done.
//  - FSM states: IDLE, RUN.
//    IDLE -> RUN on start=1: load A, B into shift regs, carry reg<=Cin, counter<=0, busy<=1.
//    RUN: each edge adds CHUNK LSBs of A/B regs plus carry reg.
//      Shift A/B right by CHUNK. Shift the CHUNK-bit result into S from the MSB end.
//      Update carry reg. Increment counter.
//    RUN -> IDLE on the edge processing chunk STEPS-1:
//      busy<=0, done<=1, Cout<=final carry, overflow<=carry-into-MSB ^ final carry.
//  - Latency: start sampled at edge t; done=1 in the cycle after edge t+STEPS, and only that cycle.
//  - S is written only by RUN. Partial S values are visible while busy=1 and are not valid.
//    Cout/overflow update only on the final step.
//  - start while busy=1: ignored; inputs not sampled.
//  - start in the done cycle (state IDLE): accepted. Back-to-back throughput is one result per STEPS+1 cycles.
//  - Arithmetic is modulo 2^WIDTH; Cout holds bit WIDTH. CHUNK==WIDTH gives STEPS=1:
//    one-cycle add, done after edge t+1.
//  - Counter width = $clog2(STEPS+1); the counter wraps only by returning to IDLE.
// STRUCTURE
//  - Shared package: state enum/localparams (IDLE, RUN) and a STEPS/counter-width helper function.
//  - One sub-module: chunk_adder #(CHUNK), a combinational ripple of full adders.
//    Outputs the CHUNK-bit sum, carry out and carry into its top bit (for overflow).
//  - Top: FSM, counter, shift registers, result registers.
// TESTING (default WIDTH=8, CHUNK=2, STEPS=4 unless stated)
//  1. A=8'h5A B=8'hA5 Cin=1, start 1 cycle -> busy 4 cycles; done after edge t+4;
//     S=8'h00 Cout=1 overflow=0.
//  2. A=8'h7F B=8'h01 Cin=0 -> S=8'h80 Cout=0 overflow=1.
//     Then A=8'hFF B=8'hFF Cin=1 -> S=8'hFF Cout=1 overflow=0.
//  3. Start accepted, inputs changed and start pulsed again at edge t+2 ->
//     the second start is ignored; result matches the first operands only.
//  4. rst_n low at edge t+2 of an operation -> all outputs 0 immediately (async);
//     no done; next start works normally.
//  5. start held high continuously -> accepted at t and t+5;
//     done pulses after edges t+4 and t+9; S held between the pulses.
//  6. WIDTH=2 CHUNK=2: (01,11,0)->S=00 Cout=1; (11,11,1)->S=11 Cout=1; (10,01,0)->S=11 Cout=0;
//     each done one cycle after start.

Source files
------------

// File: rtl/multicycle_adder_pkg.sv
// Shared types and sizing helpers for the chunk-serial multicycle adder.
package multicycle_adder_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  function automatic int unsigned calc_steps(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Counter must be able to represent Steps itself, hence the +1.
  function automatic int unsigned calc_cnt_width(input int unsigned width,
                                                 input int unsigned chunk);
    return $clog2(width / chunk + 1);
  endfunction

endpackage

// File: rtl/multicycle_adder_chunk_adder.sv
// Combinational ripple of CHUNK full adders; also exposes the carry into the top bit.
module chunk_adder #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [CHUNK:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < CHUNK; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = carry[CHUNK];
  assign cmsb_o = carry[CHUNK-1];

endmodule

// File: rtl/multicycle_adder.sv
// N-bit adder computing A+B+Cin CHUNK bits per cycle, with start/busy/done handshake
// and registered sum, carry-out and signed-overflow flags.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int unsigned Steps = calc_steps(WIDTH, CHUNK);
  localparam int unsigned CntW  = calc_cnt_width(WIDTH, CHUNK);

  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t LastCnt = cnt_t'(Steps - 1);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("multicycle_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e           state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout, chunk_cmsb;

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a_i    (a_q[CHUNK-1:0]),
    .b_i    (b_q[CHUNK-1:0]),
    .cin_i  (carry_q),
    .sum_o  (chunk_sum),
    .cout_o (chunk_cout),
    .cmsb_o (chunk_cmsb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          cnt_d   = '0;
        end
      end
      StRun: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        // Each chunk result enters at the MSB end so the sum is LSB-aligned after Steps shifts.
        s_d     = (s_q >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));
        carry_d = chunk_cout;
        cnt_d   = cnt_q + cnt_t'(1);
        if (cnt_q == LastCnt) begin
          state_d = StIdle;
          done_d  = 1'b1;
          cout_d  = chunk_cout;
          ovf_d   = chunk_cmsb ^ chunk_cout;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy_o     = (state_q == StRun);
  assign done_o     = done_q;
  assign s_o        = s_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder: 8-bit/2-bit-chunk instance plus a 2-bit single-step one.
module tb_multicycle_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cin, busy, done, cout, ovf;
  logic [7:0] a, b, s;
  logic       start2, cin2, busy2, done2, cout2, ovf2;
  logic [1:0] a2, b2, s2;

  always #5 clk = ~clk;

  multicycle_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk_i (clk), .rst_n (rst_n), .start_i (start), .a_i (a), .b_i (b), .cin_i (cin),
    .busy_o (busy), .done_o (done), .s_o (s), .cout_o (cout), .overflow_o (ovf)
  );

  multicycle_adder #(.WIDTH(2), .CHUNK(2)) dut2 (
    .clk_i (clk), .rst_n (rst_n), .start_i (start2), .a_i (a2), .b_i (b2), .cin_i (cin2),
    .busy_o (busy2), .done_o (done2), .s_o (s2), .cout_o (cout2), .overflow_o (ovf2)
  );

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] r;
    exp_t       e;
    r      = {1'b0, x} + {1'b0, y} + {8'd0, c};
    e.s    = r[7:0];
    e.cout = r[8];
    e.ovf  = (x[7] == y[7]) && (r[7] != x[7]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_result(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_S"}, 32'(s), 32'(e.s));
      check({tag, "_Cout"}, 32'(cout), 32'(e.cout));
      check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
    end
  endtask

  // Called just after the accepting edge; counts edges until done rises (bounded).
  task automatic wait_done(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_cycles));
  endtask

  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic c);
    a = x; b = y; cin = c; start = 1'b1;
    sb.push_back(model(x, y, c));
    tick();
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(tag, 4);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    expect_result(tag);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic run2(input string tag, input logic [1:0] x, input logic [1:0] y,
                      input logic c, input logic [1:0] es, input logic ec);
    a2 = x; b2 = y; cin2 = c; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check({tag, "_busy"}, 32'(busy2), 32'd1);
    tick();
    check({tag, "_done"}, 32'(done2), 32'd1);
    check({tag, "_S"}, 32'(s2), 32'(es));
    check({tag, "_Cout"}, 32'(cout2), 32'(ec));
  endtask

  initial begin
    int   nd;
    int   d1;
    int   d2;
    exp_t first;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_S", 32'(s), 32'd0);
    check("rst_Cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic operations
    run_op("t1", 8'h5A, 8'hA5, 1'b1);
    check("t1_S_held", 32'(s), 32'h00);
    run_op("t2a", 8'h7F, 8'h01, 1'b0);
    run_op("t2b", 8'hFF, 8'hFF, 1'b1);

    // Start while busy must be ignored
    a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
    sb.push_back(model(8'h33, 8'h44, 1'b0));
    tick();
    start = 1'b0;
    tick();
    a = 8'hFF; b = 8'h01; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t3", 2);
    expect_result("t3");
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) nd++;
    end
    check("t3_no_second_op", 32'(nd), 32'd0);

    // Asynchronous reset mid-operation
    a = 8'h5A; b = 8'h5A; cin = 1'b0; start = 1'b1;
    sb.push_back(model(8'h5A, 8'h5A, 1'b0));
    tick();
    start = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_S", 32'(s), 32'd0);
    check("t4_Cout", 32'(cout), 32'd0);
    check("t4_ovf", 32'(ovf), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) nd++;
    end
    check("t4_no_done", 32'(nd), 32'd0);
    run_op("t4_after", 8'h10, 8'h20, 1'b1);

    // start held high: back-to-back operations
    first = model(8'h12, 8'h34, 1'b0);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    sb.push_back(first);
    tick();
    a = 8'h80; b = 8'h80; cin = 1'b1;
    sb.push_back(model(8'h80, 8'h80, 1'b1));
    nd = 0; d1 = -1; d2 = -1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 5) begin
        check("t5_reaccepted_busy", 32'(busy), 32'd1);
        check("t5_S_held", 32'(s), 32'(first.s));
      end
      if (done) begin
        nd++;
        if (d1 < 0) d1 = k;
        else d2 = k;
        expect_result("t5");
      end
    end
    start = 1'b0;
    check("t5_done_count", 32'(nd), 32'd2);
    check("t5_first_done", 32'(d1), 32'd4);
    check("t5_second_done", 32'(d2), 32'd9);
    tick();
    check("t5_idle", 32'(busy), 32'd0);

    // Single-step configuration
    run2("t6a", 2'b01, 2'b11, 1'b0, 2'b00, 1'b1);
    run2("t6b", 2'b11, 2'b11, 1'b1, 2'b11, 1'b1);
    run2("t6c", 2'b10, 2'b01, 1'b0, 2'b11, 1'b0);
    tick();
    check("t6_done_pulse", 32'(done2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
